imem_loader: RTL

- Writer side of the instruction memory: receives a byte-serial program image and writes it, word by word, into the instruction memory write port.
- Holds the CPU (PC write disabled) for the whole load, then pulses a PC clear so fetch restarts at address 0.
- Sits between a host byte source (UART receiver or testbench) and the instruction memory / PC write-enable logic.

---
 rtl/imem_pkg.sv | 18 +
 rtl/imem_word_assembler.sv | 62 ++++++
 rtl/imem_loader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and sizes for the instruction-memory loader.
// No logic; constants and the loader state encoding only.
// Imported by imem_loader and imem_word_assembler.
package imem_pkg;

    localparam int IMEM_ADDR_W = 8;
    localparam int WORD_W      = 32;

    typedef enum logic [2:0] {
        IDLE,
        GET_CNT,
        GET_DATA,
        GET_CHK,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs big-endian stream bytes into 32-bit words and keeps the running XOR checksum.
// Latency: word_rdy_o pulses one cycle after the 4th byte of a word is accepted.
// Backpressure: none; it takes one byte per cycle whenever byte_vld_i is high.
module imem_word_assembler
    import imem_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              byte_vld_i,
    input  logic [7:0]        byte_dat_i,
    output logic              last_byte_o,
    output logic              word_rdy_o,
    output logic [WORD_W-1:0] word_o,
    output logic [7:0]        chk_o
);

    logic [WORD_W-1:0] shift_q, shift_d;
    logic [1:0]        idx_q, idx_d;
    logic [7:0]        chk_q, chk_d;
    logic              rdy_q, rdy_d;

    // The byte at index 3 completes the current word.
    assign last_byte_o = byte_vld_i && (idx_q == 2'd3);
    assign word_rdy_o  = rdy_q;
    assign word_o      = shift_q;
    assign chk_o       = chk_q;

    // Next state: shift in MSB-first, fold each byte into the checksum, flag completed words.
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        chk_d   = chk_q;
        rdy_d   = 1'b0;
        if (clr_i) begin
            shift_d = '0;
            idx_d   = '0;
            chk_d   = '0;
        end else if (byte_vld_i) begin
            shift_d = {shift_q[WORD_W-9:0], byte_dat_i};
            idx_d   = idx_q + 2'd1;
            chk_d   = chk_q ^ byte_dat_i;
            rdy_d   = (idx_q == 2'd3);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q <= '0;
            idx_q   <= '0;
            chk_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
            chk_q   <= chk_d;
            rdy_q   <= rdy_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a COUNT/data/CHK byte stream into instruction memory while holding the CPU.
// Latency: each word is written the cycle after its 4th byte; status updates one cycle after CHK.
// Backpressure: byte_ready is high in every receiving state, so the source is never stalled mid-load.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W  = IMEM_ADDR_W,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              pc_clear,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_cnt
);

    localparam int              TMO_W    = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [ADDR_W:0]  CNT_ONE  = (ADDR_W + 1)'(1);

    state_t            state_q, state_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;
    logic              pc_clear_q, pc_clear_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_W:0]   total_q, total_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic              xfer;
    logic              asm_clr;
    logic              last_byte;
    logic              word_rdy;
    logic [WORD_W-1:0] asm_word;
    logic [7:0]        asm_chk;

    assign byte_ready = (state_q == GET_CNT) || (state_q == GET_DATA) || (state_q == GET_CHK);
    assign xfer       = byte_valid && byte_ready;

    imem_word_assembler u_asm (
        .clk_i       (clk),
        .rst_i       (rst),
        .clr_i       (asm_clr),
        .byte_vld_i  (xfer && (state_q == GET_DATA)),
        .byte_dat_i  (byte_data),
        .last_byte_o (last_byte),
        .word_rdy_o  (word_rdy),
        .word_o      (asm_word),
        .chk_o       (asm_chk)
    );

    // A write pending while reset is asserted must never reach the memory.
    assign mem_we    = word_rdy && !rst;
    assign mem_addr  = word_cnt_q[ADDR_W-1:0];
    assign mem_wdata = asm_word;
    assign cpu_hold  = cpu_hold_q;
    assign pc_clear  = pc_clear_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;
    assign word_cnt  = word_cnt_q;

    // Next state: load sequencing, status flags, word counting and the idle timeout.
    always_comb begin
        state_d     = state_q;
        cpu_hold_d  = cpu_hold_q;
        load_done_d = load_done_q;
        load_err_d  = load_err_q;
        pc_clear_d  = 1'b0;
        total_d     = total_q;
        tmo_d       = tmo_q;
        asm_clr     = 1'b0;
        word_cnt_d  = word_rdy ? (word_cnt_q + CNT_ONE) : word_cnt_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (load_start) begin
                    state_d     = GET_CNT;
                    cpu_hold_d  = 1'b1;
                    load_done_d = 1'b0;
                    load_err_d  = 1'b0;
                    word_cnt_d  = '0;
                    tmo_d       = '0;
                    asm_clr     = 1'b1;
                end
            end
            GET_CNT: begin
                if (xfer) begin
                    total_d = {{(ADDR_W - 7){1'b0}}, byte_data} + CNT_ONE;
                    state_d = GET_DATA;
                end
            end
            GET_DATA: begin
                // Move on as the last word completes; its write lands in the
                // following cycle, so a CHK byte sent back-to-back is still caught.
                if (last_byte && ((word_cnt_q + CNT_ONE) == total_q)) begin
                    state_d = GET_CHK;
                end
            end
            GET_CHK: begin
                if (xfer) begin
                    if (byte_data == asm_chk) begin
                        state_d     = DONE;
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                        pc_clear_d  = 1'b1;
                    end else begin
                        state_d    = ERR;
                        load_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Idle watchdog while receiving; a transfer always wins over expiry.
        if (byte_ready) begin
            if (xfer) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                state_d    = ERR;
                load_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_ONE;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cpu_hold_q  <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            pc_clear_q  <= 1'b0;
            word_cnt_q  <= '0;
            total_q     <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
            pc_clear_q  <= pc_clear_d;
            word_cnt_q  <= word_cnt_d;
            total_q     <= total_d;
            tmo_q       <= tmo_d;
        end
    end

endmodule
